// File: rtl/bcd_seq_adder.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_seq_adder
//  Description : Digit-serial BCD adder, one digit per clock, LSD first.
//                Optional subtraction (nines complement of B) when the
//                macro BCD_SUB_EN is defined.
//  Revision    : 1.0  initial release
// ============================================================================
module bcd_seq_adder #(
  parameter int DIGITS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [4*DIGITS-1:0] a,
  input  logic [4*DIGITS-1:0] b,
  input  logic                cin,
`ifdef BCD_SUB_EN
  input  logic                sub,
`endif
  output logic                busy,
  output logic                done,
  output logic [4*DIGITS-1:0] sum,
  output logic                cout,
  output logic                invalid
);

  localparam int              IDXW   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IDXW-1:0] C_LAST = IDXW'(DIGITS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              r_state;
  logic [IDXW-1:0]     r_idx;
  logic [4*DIGITS-1:0] r_a;
  logic [4*DIGITS-1:0] r_b;
  logic                r_c;
`ifdef BCD_SUB_EN
  logic                r_sub;
`endif

  logic [3:0] w_ad;
  logic [3:0] w_bd;
  logic [3:0] w_beff;
  logic [4:0] w_s;
  logic [3:0] w_digit;
  logic       w_carry;
  logic       w_bad;

  always_comb begin
    w_ad = '0;
    w_bd = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (r_idx == IDXW'(i)) begin
        w_ad = r_a[4*i +: 4];
        w_bd = r_b[4*i +: 4];
      end
    end
`ifdef BCD_SUB_EN
    w_beff = r_sub ? (4'd9 - w_bd) : w_bd;
`else
    w_beff = w_bd;
`endif
    // Max raw sum is 15+15+1 = 31, so five bits never overflow
    w_s     = {1'b0, w_ad} + {1'b0, w_beff} + {4'b0000, r_c};
    w_carry = (w_s > 5'd9);
    w_digit = w_carry ? 4'(w_s + 5'd6) : w_s[3:0];
    w_bad   = (w_ad > 4'd9) || (w_bd > 4'd9);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_idx   <= '0;
      sum     <= '0;
      cout    <= 1'b0;
      done    <= 1'b0;
      busy    <= 1'b0;
      invalid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_a     <= a;
            r_b     <= b;
`ifdef BCD_SUB_EN
            r_sub   <= sub;
            r_c     <= sub ? 1'b1 : cin;
`else
            r_c     <= cin;
`endif
            sum     <= '0;
            cout    <= 1'b0;
            invalid <= 1'b0;
            r_idx   <= '0;
            busy    <= 1'b1;
            r_state <= RUN;
          end
        end
        RUN: begin
          for (int i = 0; i < DIGITS; i++) begin
            if (r_idx == IDXW'(i)) begin
              sum[4*i +: 4] <= w_digit;
            end
          end
          r_c <= w_carry;
          if (w_bad) begin
            invalid <= 1'b1;
          end
          if (r_idx == C_LAST) begin
            cout    <= w_carry;
            done    <= 1'b1;
            r_state <= DONE;
          end else begin
            r_idx <= r_idx + IDXW'(1);
          end
        end
        DONE: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bcd_seq_adder.sv
`default_nettype none
// Directed testbench for bcd_seq_adder (DIGITS=4); the subtraction test is
// compiled in only when BCD_SUB_EN is defined.
`timescale 1ns/1ps
module tb_bcd_seq_adder;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] a;
  logic [15:0] b;
  logic        cin;
  logic        sub;
  logic        busy;
  logic        done;
  logic [15:0] sum;
  logic        cout;
  logic        invalid;

  int checks;
  int failures;

  bcd_seq_adder #(.DIGITS(4)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .a      (a),
    .b      (b),
    .cin    (cin),
`ifdef BCD_SUB_EN
    .sub    (sub),
`endif
    .busy   (busy),
    .done   (done),
    .sum    (sum),
    .cout   (cout),
    .invalid(invalid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Starts an operation and waits (bounded) for done; lat = edges after the
  // accepting edge, -1 on timeout. Returns 1ns after the done edge.
  task automatic run_op(input logic [15:0] ta, input logic [15:0] tb_v,
                        input logic tcin, input logic tsub, output int lat);
    a = ta; b = tb_v; cin = tcin; sub = tsub; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (done) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (sum !== 16'h0000) begin failures++; $display("FAIL reset_sum got=%h exp=0000", sum); end
    checks++; if (cout !== 1'b0) begin failures++; $display("FAIL reset_cout got=%b exp=0", cout); end
    checks++; if (invalid !== 1'b0) begin failures++; $display("FAIL reset_invalid got=%b exp=0", invalid); end
  endtask

  task automatic test_basic();
    int ndone;
    a = 16'h1234; b = 16'h5678; cin = 1'b0; sub = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL basic_busy_T got=%b exp=1", busy); end
    ndone = 0;
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    checks++; if (ndone !== 0) begin failures++; $display("FAIL basic_early_done got=%0d exp=0", ndone); end
    @(posedge clk); #1;
    checks++; if (done !== 1'b1) begin failures++; $display("FAIL basic_done_T4 got=%b exp=1", done); end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL basic_busy_done got=%b exp=1", busy); end
    checks++; if (sum !== 16'h6912) begin failures++; $display("FAIL basic_sum got=%h exp=6912", sum); end
    checks++; if (cout !== 1'b0) begin failures++; $display("FAIL basic_cout got=%b exp=0", cout); end
    checks++; if (invalid !== 1'b0) begin failures++; $display("FAIL basic_invalid got=%b exp=0", invalid); end
    @(posedge clk); #1;
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL basic_done_pulse got=%b exp=0", done); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL basic_busy_end got=%b exp=0", busy); end
    checks++; if (sum !== 16'h6912) begin failures++; $display("FAIL basic_sum_hold got=%h exp=6912", sum); end
  endtask

  task automatic test_carry();
    int lat;
    run_op(16'h9999, 16'h0001, 1'b0, 1'b0, lat);
    checks++; if (lat !== 4) begin failures++; $display("FAIL carry1_latency got=%0d exp=4", lat); end
    checks++; if (sum !== 16'h0000) begin failures++; $display("FAIL carry1_sum got=%h exp=0000", sum); end
    checks++; if (cout !== 1'b1) begin failures++; $display("FAIL carry1_cout got=%b exp=1", cout); end
    @(posedge clk); #1;
    run_op(16'h0000, 16'h0000, 1'b1, 1'b0, lat);
    checks++; if (lat !== 4) begin failures++; $display("FAIL carry2_latency got=%0d exp=4", lat); end
    checks++; if (sum !== 16'h0001) begin failures++; $display("FAIL carry2_sum got=%h exp=0001", sum); end
    checks++; if (cout !== 1'b0) begin failures++; $display("FAIL carry2_cout got=%b exp=0", cout); end
    @(posedge clk); #1;
    run_op(16'h0958, 16'h0047, 1'b1, 1'b0, lat);
    checks++; if (sum !== 16'h1006) begin failures++; $display("FAIL carry3_sum got=%h exp=1006", sum); end
    @(posedge clk); #1;
  endtask

  task automatic test_start_ignored();
    int ndone;
    logic [15:0] sum_at_done;
    a = 16'h1234; b = 16'h5678; cin = 1'b0; sub = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    ndone = 0;
    sum_at_done = '0;
    @(posedge clk); #1;
    a = 16'h1111; b = 16'h1111; cin = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (done) begin
        ndone++;
        sum_at_done = sum;
      end
      @(posedge clk); #1;
    end
    checks++; if (ndone !== 1) begin failures++; $display("FAIL ignore_done_count got=%0d exp=1", ndone); end
    checks++; if (sum_at_done !== 16'h6912) begin failures++; $display("FAIL ignore_sum got=%h exp=6912", sum_at_done); end
    checks++; if (sum !== 16'h6912) begin failures++; $display("FAIL ignore_sum_hold got=%h exp=6912", sum); end
  endtask

  task automatic test_mid_reset();
    int ndone;
    a = 16'h1234; b = 16'h5678; cin = 1'b1; sub = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL midrst_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL midrst_done got=%b exp=0", done); end
    checks++; if (sum !== 16'h0000) begin failures++; $display("FAIL midrst_sum got=%h exp=0000", sum); end
    checks++; if (cout !== 1'b0) begin failures++; $display("FAIL midrst_cout got=%b exp=0", cout); end
    ndone = 0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    checks++; if (ndone !== 0) begin failures++; $display("FAIL midrst_no_done got=%0d exp=0", ndone); end
  endtask

  task automatic test_invalid();
    int lat;
    run_op(16'h00A0, 16'h0000, 1'b0, 1'b0, lat);
    checks++; if (invalid !== 1'b1) begin failures++; $display("FAIL invalid_flag got=%b exp=1", invalid); end
    checks++; if (sum !== 16'h0100) begin failures++; $display("FAIL invalid_sum got=%h exp=0100", sum); end
    @(posedge clk); #1;
    checks++; if (invalid !== 1'b1) begin failures++; $display("FAIL invalid_hold got=%b exp=1", invalid); end
    run_op(16'h0005, 16'h0004, 1'b0, 1'b0, lat);
    checks++; if (sum !== 16'h0009) begin failures++; $display("FAIL invalid_next_sum got=%h exp=0009", sum); end
    checks++; if (invalid !== 1'b0) begin failures++; $display("FAIL invalid_next_flag got=%b exp=0", invalid); end
    @(posedge clk); #1;
  endtask

`ifdef BCD_SUB_EN
  task automatic test_sub();
    int lat;
    run_op(16'h0100, 16'h0001, 1'b0, 1'b1, lat);
    checks++; if (sum !== 16'h0099) begin failures++; $display("FAIL sub1_sum got=%h exp=0099", sum); end
    checks++; if (cout !== 1'b1) begin failures++; $display("FAIL sub1_cout got=%b exp=1", cout); end
    @(posedge clk); #1;
    run_op(16'h0001, 16'h0002, 1'b1, 1'b1, lat);
    checks++; if (sum !== 16'h9999) begin failures++; $display("FAIL sub2_sum got=%h exp=9999", sum); end
    checks++; if (cout !== 1'b0) begin failures++; $display("FAIL sub2_cout got=%b exp=0", cout); end
    @(posedge clk); #1;
  endtask
`endif

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_basic();
    test_carry();
    test_start_ignored();
    test_mid_reset();
    test_invalid();
`ifdef BCD_SUB_EN
    test_sub();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
